disp_frame_crc: RTL and testbench

// - Downstream display-stream consumer: taps the system display outputs (x, y, de,

---
 rtl/disp_frame_crc.sv | 138 +++++++++++++
 tb/tb_disp_frame_crc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_frame_crc.sv
// Per-frame CRC-32 (zlib-compatible) signature, pixel/line counts and geometry check for a display stream.
// Optional golden-CRC compare (crc_expect/crc_match/crc_fail) is built when DISP_CRC_CHECK_EN is defined.
module disp_frame_crc #(
  parameter int BPC        = 5,
  parameter int CORDW      = 16,
  parameter int EXP_WIDTH  = 672,
  parameter int EXP_HEIGHT = 384
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CORDW-1:0] disp_x,
  input  logic signed [CORDW-1:0] disp_y,
  input  logic                    disp_de,
  input  logic                    disp_frame,
  input  logic [BPC-1:0]          disp_r,
  input  logic [BPC-1:0]          disp_g,
  input  logic [BPC-1:0]          disp_b,
`ifdef DISP_CRC_CHECK_EN
  input  logic [31:0]             crc_expect,
  output logic                    crc_match,
  output logic                    crc_fail,
`endif
  output logic [31:0]             crc_out,
  output logic                    crc_valid,
  output logic [23:0]             px_count,
  output logic [15:0]             line_count,
  output logic                    geom_err,
  output logic [15:0]             frame_count
);

  localparam int          PW     = 8 * ((3 * BPC + 7) / 8);
  localparam logic [31:0] POLY   = 32'hEDB88320;
  localparam logic [23:0] EXP_PX = 24'(EXP_WIDTH * EXP_HEIGHT);
  localparam logic [15:0] EXP_LN = 16'(EXP_HEIGHT);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   acc;
  logic [23:0]   px_acc;
  logic [15:0]   ln_acc;
  logic          prev_de;

  logic [PW-1:0] pix_word;
  logic [31:0]   seed;
  logic [31:0]   acc_nxt;
  logic [23:0]   px_base;
  logic [23:0]   px_nxt;
  logic [15:0]   ln_base;
  logic [15:0]   ln_nxt;
  logic          de_rise;
  logic          report;
  logic          accumulate;
  logic          geom_bad;

  // Coordinates are debug-only taps; reduce them so they are visibly consumed.
  logic unused_xy;
  assign unused_xy = ^{disp_x, disp_y};

  // Reflected CRC, bytes LSB first == word bits processed LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PW-1:0] w);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < PW; i++) begin
      r = (r[0] ^ w[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign pix_word   = PW'({disp_r, disp_g, disp_b});
  assign report     = disp_frame && (state == S_RUN);
  assign accumulate = disp_frame || (state == S_RUN);
  assign geom_bad   = (px_acc != EXP_PX) || (ln_acc != EXP_LN) ||
                      (px_acc == '1) || (ln_acc == '1);

  // On a frame pulse the bases reload first, so a coincident pixel opens the new frame.
  always_comb begin
    seed    = disp_frame ? '1 : acc;
    px_base = disp_frame ? '0 : px_acc;
    ln_base = disp_frame ? '0 : ln_acc;
    de_rise = disp_de && (disp_frame || !prev_de);
    acc_nxt = disp_de ? crc_step(seed, pix_word) : seed;
    px_nxt  = (disp_de && (px_base != '1)) ? px_base + 24'd1 : px_base;
    ln_nxt  = (de_rise && (ln_base != '1)) ? ln_base + 16'd1 : ln_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT;
      acc         <= '1;
      px_acc      <= '0;
      ln_acc      <= '0;
      prev_de     <= 1'b0;
      crc_out     <= '0;
      crc_valid   <= 1'b0;
      px_count    <= '0;
      line_count  <= '0;
      geom_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      crc_valid <= 1'b0;
      if (report) begin
        crc_out     <= ~acc;
        px_count    <= px_acc;
        line_count  <= ln_acc;
        geom_err    <= geom_bad;
        crc_valid   <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
      if (disp_frame) begin
        state <= S_RUN;
      end
      if (accumulate) begin
        acc     <= acc_nxt;
        px_acc  <= px_nxt;
        ln_acc  <= ln_nxt;
        prev_de <= disp_de;
      end
    end
  end

`ifdef DISP_CRC_CHECK_EN
  logic crc_eq;
  assign crc_eq = (~acc == crc_expect);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_match <= 1'b0;
      crc_fail  <= 1'b0;
    end else if (report) begin
      crc_match <= crc_eq;
      crc_fail  <= crc_fail | ~crc_eq;
    end
  end
`endif

endmodule

// File: tb/tb_disp_frame_crc.sv
// Bench for disp_frame_crc: frame-level byte-queue model with table-driven zlib CRC, per-cycle compare,
// plus literal expectations. Reduced geometry keeps full-frame runs short.
`timescale 1ns/1ps
module tb_disp_frame_crc;
  localparam int BPC   = 5;
  localparam int CORDW = 16;
  localparam int EW    = 24;
  localparam int EH    = 6;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [CORDW-1:0] disp_x = '0;
  logic signed [CORDW-1:0] disp_y = '0;
  logic                    disp_de = 1'b0;
  logic                    disp_frame = 1'b0;
  logic [BPC-1:0]          disp_r = '0;
  logic [BPC-1:0]          disp_g = '0;
  logic [BPC-1:0]          disp_b = '0;
  logic [31:0]             crc_out;
  logic                    crc_valid;
  logic [23:0]             px_count;
  logic [15:0]             line_count;
  logic                    geom_err;
  logic [15:0]             frame_count;
`ifdef DISP_CRC_CHECK_EN
  logic [31:0]             crc_expect = 32'hDEADBEEF;
  logic                    crc_match;
  logic                    crc_fail;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  disp_frame_crc #(
    .BPC(BPC), .CORDW(CORDW), .EXP_WIDTH(EW), .EXP_HEIGHT(EH)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_x(disp_x), .disp_y(disp_y),
    .disp_de(disp_de), .disp_frame(disp_frame),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
`ifdef DISP_CRC_CHECK_EN
    .crc_expect(crc_expect), .crc_match(crc_match), .crc_fail(crc_fail),
`endif
    .crc_out(crc_out), .crc_valid(crc_valid), .px_count(px_count),
    .line_count(line_count), .geom_err(geom_err), .frame_count(frame_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: byte-wise zlib CRC over each whole frame's byte list
  logic [31:0] tbl [256];

  function automatic logic [31:0] zlib_crc(input byte unsigned q[$]);
    logic [31:0] c;
    c = '1;
    foreach (q[i]) c = tbl[c[7:0] ^ q[i]] ^ (c >> 8);
    return ~c;
  endfunction

  byte unsigned fbytes[$];
  bit           m_run  = 1'b0;
  bit           m_prev = 1'b0;
  int unsigned  m_px   = 0;
  int unsigned  m_ln   = 0;
  logic [31:0]  e_crc  = '0;
  logic [23:0]  e_px   = '0;
  logic [15:0]  e_ln   = '0;
  logic         e_geom = 1'b0;
  logic         e_valid = 1'b0;
  logic [15:0]  e_fc   = '0;
  logic [15:0]  pw;
`ifdef DISP_CRC_CHECK_EN
  logic         e_match = 1'b0;
  logic         e_fail  = 1'b0;
`endif

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_prev = 0; m_px = 0; m_ln = 0; fbytes.delete();
      e_crc = '0; e_px = '0; e_ln = '0; e_geom = 0; e_valid = 0; e_fc = '0;
`ifdef DISP_CRC_CHECK_EN
      e_match = 0; e_fail = 0;
`endif
    end else begin
      e_valid = 0;
      if (disp_frame) begin
        if (m_run) begin
          e_crc   = zlib_crc(fbytes);
          e_px    = (m_px >= 32'hFFFFFF) ? 24'hFFFFFF : 24'(m_px);
          e_ln    = (m_ln >= 32'hFFFF) ? 16'hFFFF : 16'(m_ln);
          e_geom  = (m_px != 32'(EW * EH)) || (m_ln != 32'(EH)) ||
                    (m_px >= 32'hFFFFFF) || (m_ln >= 32'hFFFF);
          e_valid = 1;
          e_fc    = e_fc + 16'd1;
`ifdef DISP_CRC_CHECK_EN
          e_match = (e_crc == crc_expect);
          e_fail  = e_fail | ~e_match;
`endif
        end
        m_run = 1; fbytes.delete(); m_px = 0; m_ln = 0; m_prev = 0;
      end
      if (m_run && disp_de) begin
        pw = {1'b0, disp_r, disp_g, disp_b};
        fbytes.push_back(pw[7:0]);
        fbytes.push_back(pw[15:8]);
        m_px++;
        if (!m_prev) m_ln++;
      end
      m_prev = disp_de;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("crc_valid", 32'(crc_valid), 32'(e_valid));
      chk("crc_out", crc_out, e_crc);
      chk("px_count", 32'(px_count), 32'(e_px));
      chk("line_count", 32'(line_count), 32'(e_ln));
      chk("geom_err", 32'(geom_err), 32'(e_geom));
      chk("frame_count", 32'(frame_count), 32'(e_fc));
`ifdef DISP_CRC_CHECK_EN
      chk("crc_match", 32'(crc_match), 32'(e_match));
      chk("crc_fail", 32'(crc_fail), 32'(e_fail));
`endif
    end
  end

  task automatic tick(input logic de, input logic fr,
                      input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b);
    @(posedge clk);
    #1;
    disp_de    = de;
    disp_frame = fr;
    disp_r     = r;
    disp_g     = g;
    disp_b     = b;
    disp_x     = CORDW'($urandom);
    disp_y     = CORDW'($urandom);
  endtask

  task automatic frame_body(input int w, input int h,
                            input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b);
    for (int l = 0; l < h; l++) begin
      repeat (4) tick(1'b0, 1'b0, '0, '0, '0);
      for (int p = 0; p < w; p++) tick(1'b1, 1'b0, r, g, b);
    end
    repeat (4) tick(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Closes the current frame and lands on the negedge where its report is visible.
  task automatic close_frame();
    tick(1'b0, 1'b1, '0, '0, '0);
    tick(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    byte unsigned q[$];
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? (32'hEDB88320 ^ (c >> 1)) : (c >> 1);
      tbl[n] = c;
    end
    q.push_back(8'h00); q.push_back(8'h00);
    chk("model_two_zero_bytes", zlib_crc(q), 32'h41D912FF);
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    chk("model_check_string", zlib_crc(q), 32'hCBF43926);

    repeat (3) tick(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_crc_out", crc_out, 32'h0);
    chk("reset_frame_count", 32'(frame_count), 32'h0);

    // Pixels before the first frame pulse are ignored; the first pulse reports nothing
    repeat (5) tick(1'b1, 1'b0, 5'd3, 5'd7, 5'd9);
    close_frame();
    chk("first_frame_no_valid", 32'(crc_valid), 32'h0);
    chk("first_frame_count", 32'(frame_count), 32'h0);

    tick(1'b1, 1'b0, '0, '0, '0);
    repeat (3) tick(1'b0, 1'b0, '0, '0, '0);
    close_frame();
    chk("one_px_valid", 32'(crc_valid), 32'h1);
    chk("one_px_crc", crc_out, 32'h41D912FF);
    chk("one_px_count", 32'(px_count), 32'd1);
    chk("one_px_lines", 32'(line_count), 32'd1);
    chk("one_px_geom", 32'(geom_err), 32'h1);
`ifdef DISP_CRC_CHECK_EN
    chk("one_px_match", 32'(crc_match), 32'h0);
    chk("one_px_fail", 32'(crc_fail), 32'h1);
    crc_expect = 32'h0;
`endif
    tick(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("valid_one_cycle", 32'(crc_valid), 32'h0);

    repeat (96) tick(1'b0, 1'b0, '0, '0, '0);
    close_frame();
    chk("empty_crc", crc_out, 32'h0);
    chk("empty_px", 32'(px_count), 32'd0);
    chk("empty_lines", 32'(line_count), 32'd0);
    chk("empty_geom", 32'(geom_err), 32'h1);
`ifdef DISP_CRC_CHECK_EN
    chk("empty_match", 32'(crc_match), 32'h1);
    chk("sticky_fail", 32'(crc_fail), 32'h1);
`endif

    for (int f = 0; f < 2; f++) begin
      frame_body(EW, EH, 5'd2, 5'd4, 5'd6);
      close_frame();
      chk("full_px", 32'(px_count), 32'(EW * EH));
      chk("full_lines", 32'(line_count), 32'(EH));
      chk("full_geom", 32'(geom_err), 32'h0);
    end

    frame_body(EW - 1, EH, 5'd17, 5'd0, 5'd31);
    close_frame();
    chk("short_line_px", 32'(px_count), 32'(( EW - 1) * EH));
    chk("short_line_geom", 32'(geom_err), 32'h1);

    repeat (5) tick(1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
    tick(1'b1, 1'b1, 5'd4, 5'd5, 5'd6);
    tick(1'b1, 1'b0, 5'd7, 5'd8, 5'd9);
    @(negedge clk);
    chk("coincide_prev_px", 32'(px_count), 32'd5);
    chk("coincide_prev_lines", 32'(line_count), 32'd1);
    repeat (2) tick(1'b1, 1'b0, 5'd10, 5'd11, 5'd12);
    repeat (2) tick(1'b0, 1'b0, '0, '0, '0);
    close_frame();
    chk("coincide_new_px", 32'(px_count), 32'd4);
    chk("coincide_new_lines", 32'(line_count), 32'd1);

    // Reset in the middle of a frame discards it entirely
    repeat (5) tick(1'b1, 1'b0, 5'd9, 5'd9, 5'd9);
    tick(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_crc", crc_out, 32'h0);
    chk("midrst_px", 32'(px_count), 32'h0);
    chk("midrst_fc", 32'(frame_count), 32'h0);
    close_frame();
    chk("midrst_no_valid", 32'(crc_valid), 32'h0);
    frame_body(EW, EH, 5'd2, 5'd4, 5'd6);
    close_frame();
    chk("after_rst_valid", 32'(crc_valid), 32'h1);
    chk("after_rst_geom", 32'(geom_err), 32'h0);
    chk("after_rst_fc", 32'(frame_count), 32'd1);

    repeat (3) tick(1'b0, 1'b0, '0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
